// File: rtl/spi_sipo_rx.sv
// spi_sipo_rx: SPI serial-in/parallel-out receiver.
// Assembles DATA_W-bit words from sdi and hands them off with valid/ack.
module spi_sipo_rx #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sdi,
  input  logic                      shift_en,
  input  logic                      frame_start,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  input  logic                      data_ack,
  output logic                      overrun,
  output logic                      busy,
  output logic [$clog2(DATA_W)-1:0] bit_cnt
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_base;
  logic [DATA_W-1:0] sr_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              comp;

  // Next shift value; frame_start restarts from an empty register.
  always_comb begin
    sr_base = frame_start ? '0 : sr;
    if (MSB_FIRST) begin
      sr_nxt = {sr_base[DATA_W-2:0], sdi};
    end else begin
      sr_nxt = {sdi, sr_base[DATA_W-1:1]};
    end
  end

  // Completion detect and next bit count (explicit wrap for any DATA_W).
  always_comb begin
    comp    = shift_en && !frame_start && (bit_cnt == LAST);
    cnt_nxt = bit_cnt;
    if (frame_start) begin
      cnt_nxt = shift_en ? CW'(1) : '0;
    end else if (shift_en) begin
      cnt_nxt = (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
    end
  end

  // Assembly state: shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      bit_cnt <= cnt_nxt;
      if (shift_en) begin
        sr <= sr_nxt;
      end else if (frame_start) begin
        sr <= '0;
      end
    end
  end

  // Output handshake: load on completion unless an unacked word blocks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (comp) begin
        if (!data_valid || data_ack) begin
          data_out   <= sr_nxt;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end
      if (frame_start) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (bit_cnt != '0);

endmodule

// File: tb/tb_spi_sipo_rx.sv
// tb_spi_sipo_rx: directed + random bench for spi_sipo_rx.
// Checks MSB-first and LSB-first instances against a bit-list model.
module tb_spi_sipo_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdi = 1'b0;
  logic       shift_en = 1'b0;
  logic       frame_start = 1'b0;
  logic       data_ack = 1'b0;

  logic [7:0] dout_m, dout_l;
  logic       val_m, val_l;
  logic       ovr_m, ovr_l;
  logic       busy_m, busy_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;

  bit         m_bits[$];
  logic [7:0] e_m, e_l;
  logic       e_v, e_o;

  always #5 clk = ~clk;

  spi_sipo_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sdi(sdi),
    .shift_en(shift_en), .frame_start(frame_start),
    .data_out(dout_m), .data_valid(val_m),
    .data_ack(data_ack), .overrun(ovr_m),
    .busy(busy_m), .bit_cnt(cnt_m)
  );

  spi_sipo_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sdi(sdi),
    .shift_en(shift_en), .frame_start(frame_start),
    .data_out(dout_l), .data_valid(val_l),
    .data_ack(data_ack), .overrun(ovr_l),
    .busy(busy_l), .bit_cnt(cnt_l)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n;
    n = m_bits.size();
    chk({tag, "_dout_m"}, 32'(dout_m), 32'(e_m));
    chk({tag, "_dout_l"}, 32'(dout_l), 32'(e_l));
    chk({tag, "_valid_m"}, 32'(val_m), 32'(e_v));
    chk({tag, "_valid_l"}, 32'(val_l), 32'(e_v));
    chk({tag, "_ovr_m"}, 32'(ovr_m), 32'(e_o));
    chk({tag, "_ovr_l"}, 32'(ovr_l), 32'(e_o));
    chk({tag, "_cnt_m"}, 32'(cnt_m), 32'(n));
    chk({tag, "_cnt_l"}, 32'(cnt_l), 32'(n));
    chk({tag, "_busy_m"}, 32'(busy_m), 32'(n != 0));
    chk({tag, "_busy_l"}, 32'(busy_l), 32'(n != 0));
  endtask

  task automatic model_reset();
    m_bits.delete();
    e_m = 8'h00;
    e_l = 8'h00;
    e_v = 1'b0;
    e_o = 1'b0;
  endtask

  // Reference: collect bits in a list; 8 collected bits form a word.
  task automatic model_edge(bit d, bit en, bit fs, bit ack);
    logic [7:0] w_m, w_l;
    if (fs) begin
      m_bits.delete();
      e_o = 1'b0;
      if (en) m_bits.push_back(d);
      if (e_v && ack) e_v = 1'b0;
    end else begin
      if (en) m_bits.push_back(d);
      if (m_bits.size() == 8) begin
        w_m = 8'h00;
        w_l = 8'h00;
        for (int i = 0; i < 8; i++) begin
          w_m[7-i] = m_bits[i];
          w_l[i]   = m_bits[i];
        end
        m_bits.delete();
        if (!e_v || ack) begin
          e_m = w_m;
          e_l = w_l;
          e_v = 1'b1;
        end else begin
          e_o = 1'b1;
        end
      end else if (e_v && ack) begin
        e_v = 1'b0;
      end
    end
  endtask

  task automatic step(bit d, bit en, bit fs, bit ack, string tag);
    sdi = d;
    shift_en = en;
    frame_start = fs;
    data_ack = ack;
    @(posedge clk);
    model_edge(d, en, fs, ack);
    #1;
    check_all(tag);
    shift_en = 1'b0;
    frame_start = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic send(logic [7:0] b, bit ack_last, int gap_pct,
                      string tag);
    for (int i = 7; i >= 0; i--) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        step(1'($urandom), 1'b0, 1'b0, 1'b0, {tag, "_gap"});
      end
      step(b[i], 1'b1, 1'b0, (i == 0) ? ack_last : 1'b0, tag);
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // T1 / T6: A5 reads the same in both bit orders.
    send(8'hA5, 1'b0, 0, "t1");
    chk("t1_dout_m_const", 32'(dout_m), 32'h A5);
    chk("t6_dout_l_const", 32'(dout_l), 32'h A5);
    chk("t1_valid_const", 32'(val_m), 32'h1);
    chk("t1_cnt_const", 32'(cnt_m), 32'h0);

    // T2: unacked word blocks the next one and flags overrun.
    send(8'h3C, 1'b0, 0, "t2");
    chk("t2_ovr_const", 32'(ovr_m), 32'h1);
    chk("t2_hold_const", 32'(dout_m), 32'hA5);
    step(1'b0, 1'b0, 1'b1, 1'b0, "t2_fs");
    chk("t2_fs_ovr_const", 32'(ovr_m), 32'h0);
    chk("t2_fs_valid_const", 32'(val_m), 32'h1);

    // T3: ack on the completing edge swaps in the new word.
    send(8'h3C, 1'b1, 0, "t3");
    chk("t3_dout_const", 32'(dout_m), 32'h3C);
    chk("t3_valid_const", 32'(val_m), 32'h1);
    chk("t3_ovr_const", 32'(ovr_m), 32'h0);

    // Ack alone drops valid.
    step(1'b0, 1'b0, 1'b0, 1'b1, "ack");
    chk("ack_valid_const", 32'(val_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "ack_idle");

    // T4: junk, then frame_start carrying bit 0 of the new word.
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, "t4_junk");
    step(1'b1, 1'b1, 1'b1, 1'b0, "t4_fs");
    chk("t4_fs_cnt_const", 32'(cnt_m), 32'h1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "t4_bits");
    step(1'b1, 1'b1, 1'b0, 1'b0, "t4_last");
    chk("t4_dout_m_const", 32'(dout_m), 32'h81);
    chk("t4_dout_l_const", 32'(dout_l), 32'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t4_ack");

    // T5: gaps are transparent; reset mid-word clears everything.
    send(8'hA5, 1'b0, 40, "t5a");
    chk("t5_gap_dout_const", 32'(dout_m), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t5_ack");
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, "t5_part");
    do_reset("t5_rst");
    send(8'h5A, 1'b0, 0, "t5b");
    chk("t5_dout_m_const", 32'(dout_m), 32'h5A);
    chk("t5_dout_l_const", 32'(dout_l), 32'h5A);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit fs;
      fs = ($urandom_range(99) < 5);
      step(1'($urandom), ($urandom_range(99) < 70), fs,
           fs ? 1'b0 : ($urandom_range(99) < 30), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
